// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (D); one outstanding access.
// Optional response timeout with sticky err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        err
);

   typedef enum logic {IDLE, WAIT_RESP} state_t;

   localparam logic        OWN_IF = 1'b0;
   localparam logic        OWN_D  = 1'b1;
   localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);
   localparam logic [31:0] NOP    = 32'h0000_0013;

   state_t      state, state_nxt;
   logic        owner, owner_nxt;
   logic [3:0]  starve_cnt, starve_nxt;
   logic        sel_d, sel_if;
   logic        timeout_hit;
   logic [31:0] resp_data;

   // D wins unless fetch has already been passed over LIMIT times in a row
   assign sel_d  = d_req && ((starve_cnt < LIMIT) || !if_req);
   assign sel_if = if_req && !sel_d;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         tmo_cnt <= (state == WAIT_RESP) ? tmo_cnt + 16'd1 : 16'd0;
         if (timeout_hit) err <= 1'b1;
      end
   end

   // A real response arriving on the deadline cycle takes priority
   assign timeout_hit = (state == WAIT_RESP) && (tmo_cnt == 16'(TIMEOUT - 1)) && !mem_rvalid;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      starve_nxt = starve_cnt;
      resp_data  = mem_rvalid ? mem_rdata : NOP;
      if_gnt     = 1'b0;
      if_rvalid  = 1'b0;
      if_rdata   = '0;
      d_gnt      = 1'b0;
      d_rvalid   = 1'b0;
      d_rdata    = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      stall      = 1'b0;
      // Outputs are held at zero for the whole time reset is asserted
      if (reset) begin
         case (state)
            IDLE: begin
               if (sel_d || sel_if) begin
                  mem_req = 1'b1;
                  if (sel_d) begin
                     mem_we    = d_we;
                     mem_addr  = d_addr;
                     mem_wdata = d_wdata;
                     mem_wstrb = d_wstrb;
                  end else begin
                     mem_addr  = if_addr;
                  end
                  if (mem_gnt) begin
                     if_gnt    = sel_if;
                     d_gnt     = sel_d;
                     owner_nxt = sel_d ? OWN_D : OWN_IF;
                     state_nxt = WAIT_RESP;
                  end
               end
            end
            WAIT_RESP: begin
               if (mem_rvalid || timeout_hit) begin
                  if (owner == OWN_D) begin
                     d_rvalid = 1'b1;
                     d_rdata  = resp_data;
                  end else begin
                     if_rvalid = 1'b1;
                     if_rdata  = resp_data;
                  end
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
         stall = (if_req && !if_gnt) || (d_req && !d_gnt) || (state == WAIT_RESP);
         if (!if_req || if_gnt)
            starve_nxt = '0;
         else if (d_gnt && (starve_cnt < LIMIT))
            starve_nxt = starve_cnt + 4'd1;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the fetch stage (IF requester) and the load/store path (D requester) of the 3-stage RV32I pipeline. It allows at most one outstanding transaction and routes each response back to the requester that owns it. It drives a pipeline stall whenever a requester is waiting, and guarantees bounded fetch latency through a starvation counter.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (1..15)
TIMEOUT, 64, cycles in WAIT_RESP without mem_rvalid before the timeout path fires (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_gnt
if_addr  input  32  fetch byte address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch data valid
if_rdata  output  32  fetch data
d_req  input  1  data request, held until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_wstrb  input  4  store byte enables
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid, or store ack
d_rdata  output  32  load data
mem_req  output  1  memory request
mem_we  output  1  memory write
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_wstrb  output  4  memory byte enables
mem_gnt  input  1  memory accepts the request this cycle
mem_rvalid  input  1  memory response, read data or write ack
mem_rdata  input  32  memory read data
stall  output  1  pipeline stall request
err  output  1  sticky timeout error

Behaviour:
- Reset: clk, with reset as the asynchronous active-low reset. Reset forces state = IDLE, owner = IF, starve_cnt = 0, err = 0, and all outputs to 0.
- States: IDLE, WAIT_RESP. A 1-bit owner register (IF/D) is latched at grant.
- Arbitration in IDLE (combinational):
  - If d_req is high and starve_cnt < STARVE_LIMIT, select D.
  - Otherwise, if if_req is high, select IF.
  - Otherwise, if d_req is high, select D.
  - mem_req = selected request. mem_addr, mem_we, mem_wdata and mem_wstrb come from the selected requester. For IF, mem_we = 0 and mem_wstrb = 0.
- Grant:
  - In IDLE with mem_req && mem_gnt, the selected requester's gnt pulses high for 1 cycle in the same cycle.
  - owner is latched and the next state is WAIT_RESP.
  - With no mem_gnt, the state stays IDLE and arbitration is re-evaluated next cycle.
- Wait: in WAIT_RESP, mem_req = 0. When mem_rvalid is high:
  - owner's rvalid = 1 and owner's rdata = mem_rdata, combinationally in the same cycle; the non-owner's rvalid = 0.
  - next state is IDLE.
  - No grant happens in the same cycle, so the minimum spacing between grants is 2 cycles.
- Stores also complete only on mem_rvalid, which acts as the ack. d_rdata is don't-care, and the bench must not check it.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each D grant while if_req is high.
  - Clears on an IF grant or on any cycle with if_req low.
- stall = (if_req && !if_gnt) || (d_req && !d_gnt) || (state == WAIT_RESP).
- mem_rvalid while in IDLE (stray, e.g. after reset mid-transaction): ignored; no rvalid is routed.
- Reset mid-transaction: the pending response is discarded. Requesters re-issue after reset.
- Address alignment is not checked here; the fetch stage owns misalignment exceptions.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs while in WAIT_RESP and clears on entry to the state.
  - On reaching TIMEOUT-1 with no mem_rvalid, the following happen in that cycle: owner's rvalid = 1, owner's rdata = 32'h0000_0013 (NOP), err is set (sticky until reset), and next state is IDLE.
  - A real mem_rvalid that arrives in the same cycle wins, and err is not set.
- Undefined: no counter; err is tied 0; WAIT_RESP waits indefinitely.

Test Plan:
- Single fetch: if_req = 1 at addr 0x100, mem_gnt = 1, mem_rvalid 2 cycles later with 0xDEADBEEF -> if_gnt pulses in the request cycle; if_rvalid = 1 with if_rdata = 0xDEADBEEF; stall high until that cycle; d_rvalid stays 0.
- Simultaneous requests: if_req = d_req = 1, memory always ready, 1-cycle response -> D granted first; IF granted 2 cycles later.
- Starvation: if_req held and d_req held continuously, STARVE_LIMIT = 4 -> exactly 4 D grants, then an IF grant; starve_cnt returns to 0.
- Store ack: d_req with d_we = 1, addr 0x200, wdata 0x12345678, wstrb 4'b0011 -> mem_we = 1 with those exact values on mem_* in the grant cycle; d_rvalid on the ack.
- Reset mid-transaction: reset asserted in WAIT_RESP, deasserted, then mem_rvalid pulses -> no if_rvalid or d_rvalid; state is IDLE; all outputs 0 during reset.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT = 8: grant, no response -> after 8 cycles the owner sees rvalid with rdata 0x00000013; err = 1 and stays 1 through later normal transactions.
